// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//   Issues word-aligned fetch requests from a fetch PC, tracks requests in
//   flight, and buffers returned words with their PCs in a 2-entry FIFO that
//   feeds decode. A redirect flushes the FIFO, restarts fetch at the new PC,
//   and discards every response still in flight for the old stream.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel (addr = fetch PC)
//   imem_resp_valid/data            in-order read response channel
//   redirect_valid/pc               taken branch/jump, new fetch address
//   inst_valid/ready                instruction handshake to decode
//   inst, inst_pc                   FIFO head: instruction word and its address
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    logic [31:0] fpc_q, fpc_d;
    logic        started_q;
    logic [1:0]  out_q, out_d;
    logic [1:0]  drop_q, drop_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] ifq_q [2];
    logic [31:0] ifq_d [2];
    logic [31:0] fi_q [2];
    logic [31:0] fi_d [2];
    logic [31:0] fp_q [2];
    logic [31:0] fp_d [2];

    logic        credit_ok;
    logic        req_fire;
    logic        resp_take;
    logic        resp_push;
    logic        pop;
    logic [1:0]  ifq_n;
    logic [1:0]  fifo_n;

    // Low address bits of a redirect target carry no meaning here.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    // Requests are only issued when the FIFO is guaranteed room for every
    // word in flight, so a response can always be pushed.
    always_comb begin
        credit_ok      = ({1'b0, out_q} + {1'b0, cnt_q}) < 3'd2;
        imem_req_valid = started_q && !redirect_valid && credit_ok;
        imem_req_addr  = fpc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_take      = imem_resp_valid && (out_q != 2'd0);
        resp_push      = resp_take && (drop_q == 2'd0) && !redirect_valid;
        inst_valid     = (cnt_q != 2'd0);
        inst           = fi_q[0];
        inst_pc        = fp_q[0];
        pop            = inst_valid && inst_ready && !redirect_valid;
    end

    always_comb begin
        fpc_d  = fpc_q;
        drop_d = drop_q;
        ifq_d  = ifq_q;
        fi_d   = fi_q;
        fp_d   = fp_q;

        // In-flight PC queue: every response (kept or dropped) retires the
        // oldest request; a new request appends behind what remains.
        ifq_n = out_q;
        if (resp_take) begin
            ifq_d[0] = ifq_q[1];
            ifq_n    = out_q - 2'd1;
        end
        if (req_fire) begin
            ifq_d[ifq_n[0]] = fpc_q;
        end
        out_d = ifq_n + (req_fire ? 2'd1 : 2'd0);

        // Everything still in flight after this cycle belongs to the old
        // stream once a redirect is seen.
        if (redirect_valid) begin
            drop_d = ifq_n;
        end else if (resp_take && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
        end

        // Output FIFO, head at index 0; pop shifts before the push lands.
        fifo_n = cnt_q;
        if (pop) begin
            fi_d[0] = fi_q[1];
            fp_d[0] = fp_q[1];
            fifo_n  = cnt_q - 2'd1;
        end
        if (resp_push) begin
            fi_d[fifo_n[0]] = imem_resp_data;
            fp_d[fifo_n[0]] = ifq_q[0];
        end
        cnt_d = redirect_valid ? 2'd0 : fifo_n + (resp_push ? 2'd1 : 2'd0);

        if (redirect_valid) begin
            fpc_d = {redirect_pc[31:2], 2'b00};
        end else if (req_fire) begin
            fpc_d = fpc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_q     <= RESET_PC;
            started_q <= 1'b0;
            out_q     <= '0;
            drop_q    <= '0;
            cnt_q     <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                ifq_q[i] <= '0;
                fi_q[i]  <= '0;
                fp_q[i]  <= '0;
            end
        end else begin
            fpc_q     <= fpc_d;
            started_q <= 1'b1;
            out_q     <= out_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
            ifq_q     <= ifq_d;
            fi_q      <= fi_d;
            fp_q      <= fp_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A small memory model answers
// requests in order (data = ~address), a scoreboard queue holds the PCs the
// instruction stream is expected to deliver, and a monitor compares every
// instruction handshake against the queue head.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    int          checks    = 0;
    int          errors    = 0;
    int          delivered = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mq [$];
    logic        mem_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_stream(input logic [31:0] start, input int n);
        logic [31:0] pc;
        exp_q.delete();
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pc);
            pc = pc + 32'd4;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Waits (bounded) at falling edges until FIFO empty and no request pending.
    task automatic wait_idle(input string name);
        int n = 0;
        neg();
        while ((inst_valid || imem_req_valid) && n < 20) begin
            n++;
            neg();
        end
        chk(name, {31'b0, inst_valid | imem_req_valid}, 32'd0);
    endtask

    task automatic wait_inst(input string name);
        int n = 0;
        neg();
        while (!inst_valid && n < 20) begin
            n++;
            neg();
        end
        chk(name, {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        neg();
        while (!imem_req_valid && n < 20) begin
            n++;
            neg();
        end
        chk(name, {31'b0, imem_req_valid}, 32'd1);
    endtask

    // Memory model: in-order, 1-cycle minimum latency, optional stall.
    initial begin
        logic        f, rv, rs;
        logic [31:0] a;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            f  = imem_req_valid && imem_req_ready;
            a  = imem_req_addr;
            rv = imem_resp_valid;
            rs = rst_n;
            @(posedge clk);
            #2;
            if (!rs) begin
                mq.delete();
            end else begin
                if (rv) void'(mq.pop_front());
                if (f) mq.push_back(a);
            end
            imem_resp_valid = (mq.size() != 0) && !mem_stall;
            imem_resp_data  = imem_resp_valid ? ~mq[0] : 32'h0;
        end
    end

    // Monitor: every accepted instruction must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got pc %h with nothing expected", inst_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", inst_pc, e);
                chk("sb_data", inst, ~e);
                delivered++;
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exp_q.delete();

        // Reset state
        repeat (3) cyc();
        neg();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_addr", imem_req_addr, 32'h0);

        // Release: the release cycle itself issues nothing, the next one does
        cyc();
        rst_n = 1'b1;
        exp_stream(32'h0, 40);
        neg();
        chk("release_cycle_req", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        neg();
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        repeat (20) cyc();
        neg();
        chk("stream_progress", {31'b0, delivered >= 8}, 32'd1);

        // Decode back-pressure: FIFO fills, requests stop, order kept
        cyc();
        inst_ready = 1'b0;
        repeat (10) cyc();
        neg();
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("stall_head_pc", inst_pc, exp_q[0]);
        cyc();
        inst_ready = 1'b1;
        repeat (6) cyc();

        // Redirect to 0x1003 with two requests outstanding
        mem_stall = 1'b1;
        wait_idle("fill_outstanding_timeout");
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1003;
        exp_stream(32'h0000_1000, 40);
        neg();
        chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        neg();
        chk("redir_addr", imem_req_addr, 32'h0000_1000);
        chk("redir_wait_drop", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        mem_stall = 1'b0;
        wait_inst("redir_inst_timeout");
        chk("redir_first_pc", inst_pc, 32'h0000_1000);
        chk("redir_first_data", inst, ~32'h0000_1000);

        // Redirect coinciding with a response and an inst handshake
        repeat (4) cyc();
        inst_ready = 1'b0;
        repeat (8) cyc();
        mem_stall  = 1'b1;
        inst_ready = 1'b1;
        neg();
        chk("coinc_a_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("coinc_a_req_valid", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        inst_ready = 1'b0;
        neg();
        chk("coinc_b_req_valid", {31'b0, imem_req_valid}, 32'd1);
        cyc();
        mem_stall      = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        exp_stream(32'h0000_2000, 40);
        neg();
        chk("coinc_c_resp", {31'b0, imem_resp_valid & inst_valid}, 32'd1);
        chk("coinc_c_req_valid", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        neg();
        chk("coinc_d_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("coinc_d_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("coinc_d_addr", imem_req_addr, 32'h0000_2000);

        // Back-to-back redirects, last one lands at the top of memory
        repeat (6) cyc();
        mem_stall = 1'b1;
        wait_idle("b2b_outstanding_timeout");
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF0;
        exp_q.delete();
        cyc();
        redirect_pc = 32'hFFFF_FFFE;
        exp_stream(32'hFFFF_FFFC, 40);
        neg();
        chk("b2b_req_valid", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        mem_stall      = 1'b0;
        neg();
        chk("b2b_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_req("wrap_req_timeout");
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        cyc();
        neg();
        chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);

        // Reset mid-stream with FIFO full and redirect asserted
        repeat (6) cyc();
        inst_ready = 1'b0;
        repeat (8) cyc();
        rst_n          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        exp_q.delete();
        cyc();
        neg();
        chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("mid_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("mid_rst_inst", inst, 32'd0);
        chk("mid_rst_inst_pc", inst_pc, 32'd0);
        chk("mid_rst_addr", imem_req_addr, 32'h0);
        cyc();
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        exp_stream(32'h0, 40);
        wait_req("resume_req_timeout");
        chk("resume_addr", imem_req_addr, 32'h0);
        wait_inst("resume_inst_timeout");
        chk("resume_first_pc", inst_pc, 32'h0);
        repeat (15) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 SHALL have port imem_req_valid, output, 1: fetch request present.
REQ-005 SHALL have port imem_req_ready, input, 1: memory accepts request; transfer occurs when valid and ready are both high.
REQ-006 SHALL have port imem_req_addr, output, 32: word-aligned fetch address.
REQ-007 SHALL have port imem_resp_valid, input, 1: read data returned; responses arrive in request order, at least 1 cycle after the request.
REQ-008 SHALL have port imem_resp_data, input, 32: fetched instruction word.
REQ-009 SHALL have port redirect_valid, input, 1: branch/jump taken; flush and restart fetch.
REQ-010 SHALL have port redirect_pc, input, 32: new fetch address; bits [1:0] are ignored and treated as 0.
REQ-011 SHALL have port inst_valid, output, 1: instruction available to decode / immediate generation.
REQ-012 SHALL have port inst_ready, input, 1: decode consumes instruction; transfer occurs when valid and ready are both high.
REQ-013 SHALL have port inst, output, 32: instruction word, driven straight to the decoder and imm_gen inst input.
REQ-014 SHALL have port inst_pc, output, 32: address of inst, used for auipc, jal and branch targets.

Function
REQ-015 SHALL hold a fetch PC register (fpc); imem_req_addr SHALL equal fpc.
REQ-016 SHALL contain a 2-entry in-order FIFO of {inst, pc} pairs; inst_valid = (count != 0); inst/inst_pc = FIFO head.
REQ-017 SHALL track outstanding (0..2): +1 on a request handshake, -1 on a non-dropped or dropped imem_resp_valid.
REQ-018 SHALL assert imem_req_valid only when redirect_valid = 0 and (outstanding + count) < 2 (credit rule; FIFO can never overflow).
REQ-019 On a request handshake, fpc SHALL advance by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000); the request pc SHALL be queued in a 2-entry in-flight pc queue.
REQ-020 On imem_resp_valid with drop_cnt = 0, SHALL push {imem_resp_data, in-flight pc head} into the FIFO in the same edge; the data is visible at inst on the next cycle (latency 1 from response).
REQ-021 A simultaneous push and pop (count = 1) SHALL leave count = 1 with the new entry at the head.
REQ-022 On redirect_valid = 1: fpc <= {redirect_pc[31:2],2'b00}; FIFO count <= 0; imem_req_valid = 0 in that cycle; inst_ready handshake in that cycle SHALL be ignored (FIFO is flushed regardless).
REQ-023 On redirect, drop_cnt SHALL be set to outstanding after accounting for any response in that same cycle (that response is itself discarded); each later response with drop_cnt > 0 SHALL decrement drop_cnt and SHALL NOT be pushed.
REQ-024 Requests to the new fpc MAY be issued from the cycle after redirect while drop_cnt > 0, subject to REQ-018.
REQ-025 Back-to-back redirects SHALL each take effect; the last one wins fpc; drop accounting SHALL remain exact.
REQ-026 imem_resp_valid with outstanding = 0 is a protocol violation and SHALL be ignored (no state change).
REQ-027 imem_req_valid, once asserted without a handshake, SHALL stay asserted with stable address unless a redirect occurs.

Reset
REQ-028 While rst_n = 0 at a clock edge: fpc <= RESET_PC; count, outstanding and drop_cnt <= 0; next-cycle imem_req_valid = 0, inst_valid = 0; inst and inst_pc <= 0.
REQ-029 Reset SHALL take priority over redirect and any handshake in the same cycle; in-flight responses from before reset are not tracked.
REQ-030 The first request SHALL be issued in the first cycle after rst_n is sampled high, with address RESET_PC.

Verification
REQ-031 Reset release, memory ready with 1-cycle latency, inst_ready = 1 -> requests at 0x0, 0x4, 0x8...; inst_pc follows 0x0, 0x4, 0x8 with matching data; sustained 1 instruction per cycle after fill.
REQ-032 inst_ready = 0 for 10 cycles -> count saturates at 2, outstanding 0, imem_req_valid = 0; on release, order preserved with no loss or duplication.
REQ-033 Redirect to 0x1003 with 2 outstanding -> next request address 0x1000; the two old responses dropped; the first inst after redirect has inst_pc = 0x1000.
REQ-034 Redirect in the same cycle as a response and an inst handshake -> the response is discarded, FIFO empty next cycle, drop_cnt = remaining outstanding.
REQ-035 fpc = 0xFFFF_FFFC -> the next request address is 0x0000_0000.
REQ-036 rst_n low mid-stream (FIFO full, redirect asserted) -> all outputs at their reset values next cycle; fetch resumes from RESET_PC.
